// File: rtl/lsu_arbiter.sv
// Two-port round-robin front end for the shared load/store unit.
// Accepts one transaction per cycle, filters illegal accesses, and returns responses after RD_LAT cycles.
module lsu_arbiter #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        we0_i,
  input  logic        we1_i,
  input  logic [2:0]  funct3_0_i,
  input  logic [2:0]  funct3_1_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] wdata0_i,
  input  logic [31:0] wdata1_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        rvalid0_o,
  output logic        rvalid1_o,
  output logic        rerr0_o,
  output logic        rerr1_o,
  output logic [31:0] rdata_o,
  output logic        lsu_wren_o,
  output logic [2:0]  lsu_funct3_o,
  output logic [31:0] lsu_addr_o,
  output logic [31:0] lsu_st_data_o,
  input  logic [31:0] lsu_ld_data_i
);

  typedef struct packed {
    logic valid;
    logic port;
    logic err;
    logic we;
  } rsp_t;

  logic prio_q, prio_d;
  logic gnt0, gnt1, any_gnt;
  logic sel_we, sel_legal;
  rsp_t pipe_q [RD_LAT];
  rsp_t rsp_out;

  function automatic logic access_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic ok;
    unique case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~addr[0];
      2'b10:   ok = (addr[1:0] == 2'b00);
      default: ok = 1'b0;
    endcase
    if (we && f3[2]) ok = 1'b0;
    return ok;
  endfunction

  // Grants are gated by reset so nothing is accepted while rst_ni is low.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_ni) begin
      if (req0_i && req1_i) begin
        gnt0 = ~prio_q;
        gnt1 = prio_q;
      end else begin
        gnt0 = req0_i;
        gnt1 = req1_i;
      end
    end
  end

  assign any_gnt = gnt0 | gnt1;

  always_comb begin
    if (gnt1) begin
      sel_we        = we1_i;
      lsu_funct3_o  = funct3_1_i;
      lsu_addr_o    = addr1_i;
      lsu_st_data_o = wdata1_i;
    end else begin
      sel_we        = we0_i;
      lsu_funct3_o  = funct3_0_i;
      lsu_addr_o    = addr0_i;
      lsu_st_data_o = wdata0_i;
    end
    sel_legal = access_legal(sel_we, lsu_funct3_o, lsu_addr_o);
  end

  assign lsu_wren_o = any_gnt & sel_we & sel_legal;
  assign gnt0_o     = gnt0;
  assign gnt1_o     = gnt1;

  always_comb begin
    prio_d = prio_q;
    if (gnt0)      prio_d = 1'b1;
    else if (gnt1) prio_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= 1'b0;
      for (int unsigned i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      prio_q    <= prio_d;
      pipe_q[0] <= '{valid: any_gnt, port: gnt1, err: ~sel_legal, we: sel_we};
      for (int unsigned i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign rsp_out   = pipe_q[RD_LAT-1];
  assign rvalid0_o = rsp_out.valid & ~rsp_out.port;
  assign rvalid1_o = rsp_out.valid &  rsp_out.port;
  assign rerr0_o   = rvalid0_o & rsp_out.err;
  assign rerr1_o   = rvalid1_o & rsp_out.err;
  assign rdata_o   = (rsp_out.valid && !rsp_out.err && !rsp_out.we) ? lsu_ld_data_i : '0;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Randomized and directed bench for lsu_arbiter at RD_LAT=1 and RD_LAT=3 against a cycle-indexed response model.
module tb_lsu_arbiter;

  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [2:0]  f3   [2];
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic [31:0] ld = '0;

  logic [1:0]  ga, gb, va, vb, ea, eb;
  logic [31:0] da, db;
  logic        wren_a, wren_b;
  logic [2:0]  f3o_a, f3o_b;
  logic [31:0] ado_a, ado_b, sto_a, sto_b;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit prio = 1'b0;
  int lat [2] = '{1, 3};
  bit pv [2][MAXC];
  bit pp [2][MAXC];
  bit pe [2][MAXC];
  bit pw [2][MAXC];

  always #5 clk = ~clk;

  lsu_arbiter #(.RD_LAT(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req[0]), .req1_i(req[1]), .we0_i(we[0]), .we1_i(we[1]),
    .funct3_0_i(f3[0]), .funct3_1_i(f3[1]), .addr0_i(addr[0]), .addr1_i(addr[1]),
    .wdata0_i(wd[0]), .wdata1_i(wd[1]),
    .gnt0_o(ga[0]), .gnt1_o(ga[1]), .rvalid0_o(va[0]), .rvalid1_o(va[1]),
    .rerr0_o(ea[0]), .rerr1_o(ea[1]), .rdata_o(da),
    .lsu_wren_o(wren_a), .lsu_funct3_o(f3o_a), .lsu_addr_o(ado_a), .lsu_st_data_o(sto_a),
    .lsu_ld_data_i(ld)
  );

  lsu_arbiter #(.RD_LAT(3)) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req[0]), .req1_i(req[1]), .we0_i(we[0]), .we1_i(we[1]),
    .funct3_0_i(f3[0]), .funct3_1_i(f3[1]), .addr0_i(addr[0]), .addr1_i(addr[1]),
    .wdata0_i(wd[0]), .wdata1_i(wd[1]),
    .gnt0_o(gb[0]), .gnt1_o(gb[1]), .rvalid0_o(vb[0]), .rvalid1_o(vb[1]),
    .rerr0_o(eb[0]), .rerr1_o(eb[1]), .rdata_o(db),
    .lsu_wren_o(wren_b), .lsu_funct3_o(f3o_b), .lsu_addr_o(ado_b), .lsu_st_data_o(sto_b),
    .lsu_ld_data_i(ld)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    else n_pass++;
  endtask

  function automatic bit legal_m(input bit w, input bit [2:0] f, input bit [31:0] a);
    int unsigned bytes;
    if (f[1:0] == 2'b11) return 1'b0;
    if (w && f[2]) return 1'b0;
    bytes = 1 << f[1:0];
    return (a % bytes) == 0;
  endfunction

  task automatic tick();
    bit [1:0]  eg;
    bit        gp, sp, exp_wren;
    bit [1:0]  ev;
    bit [1:0]  ee;
    bit [31:0] ed;
    eg = '0;
    gp = 1'b0;
    if (!rst_n) begin
      prio = 1'b0;
      for (int k = 0; k < 2; k++)
        for (int i = cyc; i < MAXC; i++) pv[k][i] = 1'b0;
    end else if (req != 2'b00) begin
      gp = (req == 2'b11) ? prio : req[1];
      eg[gp] = 1'b1;
      prio = ~gp;
      for (int k = 0; k < 2; k++) begin
        pv[k][cyc + lat[k]] = 1'b1;
        pp[k][cyc + lat[k]] = gp;
        pe[k][cyc + lat[k]] = ~legal_m(we[gp], f3[gp], addr[gp]);
        pw[k][cyc + lat[k]] = we[gp];
      end
    end
    sp = eg[1];
    exp_wren = (eg != 2'b00) && we[sp] && legal_m(we[sp], f3[sp], addr[sp]);
    @(negedge clk);
    chk("gnt_a", 64'(ga), 64'(eg));
    chk("gnt_b", 64'(gb), 64'(eg));
    chk("bus_a", {28'd0, wren_a, f3o_a, ado_a}, {28'd0, exp_wren, f3[sp], addr[sp]});
    chk("bus_b", {28'd0, wren_b, f3o_b, ado_b}, {28'd0, exp_wren, f3[sp], addr[sp]});
    chk("stdata", {sto_a, sto_b}, {wd[sp], wd[sp]});
    for (int k = 0; k < 2; k++) begin
      ev = '0;
      ee = '0;
      ed = '0;
      if (pv[k][cyc]) begin
        ev[pp[k][cyc]] = 1'b1;
        ee[pp[k][cyc]] = pe[k][cyc];
        if (!pe[k][cyc] && !pw[k][cyc]) ed = ld;
      end
      if (k == 0) chk("rsp_lat1", {26'd0, va, ea, da}, {26'd0, ev, ee, ed});
      else        chk("rsp_lat3", {26'd0, vb, eb, db}, {26'd0, ev, ee, ed});
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < 2; p++) if (eg[p]) req[p] = 1'b0;
  endtask

  task automatic set_req(input int p, input bit w, input bit [2:0] f, input bit [31:0] a, input bit [31:0] d);
    req[p]  = 1'b1;
    we[p]   = w;
    f3[p]   = f;
    addr[p] = a;
    wd[p]   = d;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    req = '0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic drive_random();
    bit [31:0] a;
    for (int p = 0; p < 2; p++) begin
      if (req[p]) begin
        if ($urandom_range(9) == 0) req[p] = 1'b0;
      end else if ($urandom_range(1) == 1) begin
        a = $urandom;
        if ($urandom_range(3) != 0) a[1:0] = 2'b00;
        set_req(p, 1'($urandom_range(1)), 3'($urandom_range(7)), a, $urandom);
      end
    end
    ld = $urandom;
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      f3[p] = '0;
      addr[p] = '0;
      wd[p] = '0;
    end
    #1;
    req = 2'b11;
    tick();
    tick();
    do_reset(1);

    set_req(0, 1'b0, 3'b010, 32'h0001_0004, 32'h0);
    tick();
    ld = 32'hDEAD_BEEF;
    tick();
    tick();
    tick();

    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1'b0, 3'b010, 32'h100 + 32'(i * 4), 32'h0);
      set_req(1, 1'b0, 3'b000, 32'h200 + 32'(i), 32'h0);
      ld = 32'hA000_0000 + 32'(i);
      tick();
    end
    req = '0;
    repeat (3) tick();

    set_req(1, 1'b1, 3'b010, 32'h0002_0000, 32'h0000_00FF);
    ld = 32'h5555_5555;
    tick();
    repeat (3) tick();

    set_req(0, 1'b1, 3'b010, 32'h0001_0002, 32'h1234_5678);
    tick();
    set_req(1, 1'b0, 3'b001, 32'h0001_0001, 32'h0);
    tick();
    set_req(0, 1'b0, 3'b011, 32'h0001_0000, 32'h0);
    ld = 32'hFFFF_FFFF;
    tick();
    set_req(1, 1'b1, 3'b100, 32'h0001_0000, 32'h0);
    tick();
    repeat (3) tick();

    set_req(0, 1'b0, 3'b010, 32'h0000_0040, 32'h0);
    tick();
    set_req(0, 1'b0, 3'b010, 32'h0000_0044, 32'h0);
    tick();
    tick();
    ld = 32'h11;
    tick();
    ld = 32'h22;
    tick();
    tick();

    set_req(0, 1'b0, 3'b010, 32'h0000_0080, 32'h0);
    set_req(1, 1'b0, 3'b010, 32'h0000_0090, 32'h0);
    tick();
    tick();
    do_reset(2);
    set_req(0, 1'b0, 3'b000, 32'h0000_0003, 32'h0);
    set_req(1, 1'b0, 3'b000, 32'h0000_0005, 32'h0);
    tick();
    repeat (4) tick();

    for (int i = 0; i < 1200; i++) begin
      drive_random();
      if ($urandom_range(199) == 0) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
